pc_unit: RTL and testbench

Program-counter sequencer sitting directly downstream of the branch comparator in the execute stage. Consumes the comparator's 1-bit result plus control-flow decode flags and operands, computes and registers the next PC, and signals fetch to flush on any taken transfer. Also provides the link value for JAL/JALR writeback and traps misaligned targets.

---
 rtl/pc_unit.sv | 146 ++++++++++++++
 tb/tb_pc_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program-counter sequencer for the execute stage
//
// Computes and registers the next PC from the branch comparator result and
// control-flow decode flags. Taken transfers pulse redirect and spend one
// FLUSH cycle. Misaligned targets go to TRAP_VEC and pulse trap.
// Also provides the JAL/JALR link value.
//
// Optional feature macro: PC_UNIT_PERF_EN (taken-transfer counter).
//
// Parameters:
//   RESET_PC   PC value loaded on reset
//   TRAP_VEC   PC value loaded on a misaligned taken target
//
// Ports:
//   clk        in   1     rising-edge clock
//   reset      in   1     synchronous active-high reset
//   in_valid   in   1     instruction presented for PC update
//   in_ready   out  1     unit accepts an instruction this cycle (state RUN)
//   is_branch  in   1     conditional branch, taken when com_res=1
//   is_jal     in   1     JAL
//   is_jalr    in   1     JALR
//   com_res    in   1     comparator result for the current instruction
//   imm        in   32    sign-extended immediate
//   rs1        in   32    JALR base operand
//   pc         out  32    current PC, registered
//   link       out  32    pc+4, combinational from the current pc
//   redirect   out  1     registered pulse: fetch restarts at pc
//   trap       out  1     registered pulse: misaligned target, pc is TRAP_VEC
//   taken_cnt  out  32    taken-transfer count (0 without PC_UNIT_PERF_EN)

module pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h8000_0100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        is_branch,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic        com_res,
   input  logic [31:0] imm,
   input  logic [31:0] rs1,
   output logic [31:0] pc,
   output logic [31:0] link,
   output logic        redirect,
   output logic        trap,
   output logic [31:0] taken_cnt
);

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t      state;
   logic        accept;
   logic        taken;
   logic        misaligned;
   logic [31:0] target;
   logic [31:0] jalr_sum;

   assign in_ready = (state == RUN);
   assign accept   = in_valid && in_ready;
   assign link     = pc + 32'd4;
   assign jalr_sum = rs1 + imm;

   // Target select, priority jalr > jal > taken branch > sequential.
   always_comb begin
      target = link;
      taken  = 1'b0;
      if (is_jalr) begin
         target = {jalr_sum[31:1], 1'b0};
         taken  = 1'b1;
      end else if (is_jal) begin
         target = pc + imm;
         taken  = 1'b1;
      end else if (is_branch && com_res) begin
         target = pc + imm;
         taken  = 1'b1;
      end
   end

   // For jalr bit 0 is already cleared, so this effectively checks bit 1.
   assign misaligned = taken && (target[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RUN;
         pc       <= RESET_PC;
         redirect <= 1'b0;
         trap     <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               redirect <= 1'b0;
               trap     <= 1'b0;
               if (accept) begin
                  if (taken) begin
                     state    <= FLUSH;
                     redirect <= 1'b1;
                     if (misaligned) begin
                        pc   <= TRAP_VEC;
                        trap <= 1'b1;
                     end else begin
                        pc <= target;
                     end
                  end else begin
                     pc <= link;
                  end
               end
            end
            FLUSH: begin
               // in_valid is ignored here; fetch is restarting at pc.
               state    <= RUN;
               redirect <= 1'b0;
               trap     <= 1'b0;
            end
            default: begin
               state    <= RUN;
               redirect <= 1'b0;
               trap     <= 1'b0;
            end
         endcase
      end
   end

`ifdef PC_UNIT_PERF_EN
   logic [31:0] cnt;

   // Counts every accepted taken transfer, trapped ones included; wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= 32'd0;
      end else if (accept && taken) begin
         cnt <= cnt + 32'd1;
      end
   end

   assign taken_cnt = cnt;
`else
   assign taken_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit

module tb_pc_unit;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        is_branch;
   logic        is_jal;
   logic        is_jalr;
   logic        com_res;
   logic [31:0] imm;
   logic [31:0] rs1;
   logic [31:0] pc;
   logic [31:0] link;
   logic        redirect;
   logic        trap;
   logic [31:0] taken_cnt;

   int total;
   int bad;
   logic [31:0] exp_pc;
   logic [31:0] exp_cnt;

   pc_unit dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .is_branch (is_branch),
      .is_jal    (is_jal),
      .is_jalr   (is_jalr),
      .com_res   (com_res),
      .imm       (imm),
      .rs1       (rs1),
      .pc        (pc),
      .link      (link),
      .redirect  (redirect),
      .trap      (trap),
      .taken_cnt (taken_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic br, input logic jal, input logic jalr,
                        input logic cr, input logic [31:0] im, input logic [31:0] r1);
      in_valid  = v;
      is_branch = br;
      is_jal    = jal;
      is_jalr   = jalr;
      com_res   = cr;
      imm       = im;
      rs1       = r1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 32'd0, 32'd0);
      tick();
      tick();
      reset = 1'b0;

      // reset state
      chk("rst_pc", pc, 32'h8000_0000);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_redirect", {31'd0, redirect}, 32'd0);
      chk("rst_trap", {31'd0, trap}, 32'd0);
      chk("rst_cnt", taken_cnt, 32'd0);
      chk("rst_link", link, 32'h8000_0004);

      // sequential accepts, one per cycle
      exp_pc = 32'h8000_0000;
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 0, 0, 32'h0000_0003, 32'd0);
         tick();
         exp_pc = exp_pc + 32'd4;
         chk("seq_pc", pc, exp_pc);
         chk("seq_redirect", {31'd0, redirect}, 32'd0);
         chk("seq_ready", {31'd0, in_ready}, 32'd1);
      end

      // pc = 0x8000_0010: taken branch back by 16
      drive(1, 1, 0, 0, 1, 32'hFFFF_FFF0, 32'd0);
      tick();
      chk("br_t_pc", pc, 32'h8000_0000);
      chk("br_t_redirect", {31'd0, redirect}, 32'd1);
      chk("br_t_ready", {31'd0, in_ready}, 32'd0);
      drive(0, 0, 0, 0, 0, 32'd0, 32'd0);
      tick();
      chk("br_t_redirect2", {31'd0, redirect}, 32'd0);
      chk("br_t_ready2", {31'd0, in_ready}, 32'd1);
      chk("br_t_pc2", pc, 32'h8000_0000);

      // walk back to 0x8000_0010, then a not-taken branch
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 0, 0, 32'd0, 32'd0);
         tick();
      end
      chk("walk_pc", pc, 32'h8000_0010);
      drive(1, 1, 0, 0, 0, 32'hFFFF_FFF0, 32'd0);
      tick();
      chk("br_nt_pc", pc, 32'h8000_0014);
      chk("br_nt_redirect", {31'd0, redirect}, 32'd0);
      chk("br_nt_ready", {31'd0, in_ready}, 32'd1);

      // JALR to a target with bit 1 set -> trap
      drive(1, 0, 0, 1, 0, 32'd0, 32'h8000_1003);
      tick();
      chk("jalr_trap_pc", pc, 32'h8000_0100);
      chk("jalr_trap_trap", {31'd0, trap}, 32'd1);
      chk("jalr_trap_redirect", {31'd0, redirect}, 32'd1);
      drive(0, 0, 0, 0, 0, 32'd0, 32'd0);
      tick();
      chk("jalr_trap_trap2", {31'd0, trap}, 32'd0);
      chk("jalr_trap_redirect2", {31'd0, redirect}, 32'd0);

      // JALR bit 0 cleared, aligned
      drive(1, 0, 0, 1, 0, 32'd0, 32'h8000_1001);
      tick();
      chk("jalr_ok_pc", pc, 32'h8000_1000);
      chk("jalr_ok_trap", {31'd0, trap}, 32'd0);
      chk("jalr_ok_redirect", {31'd0, redirect}, 32'd1);
      drive(0, 0, 0, 0, 0, 32'd0, 32'd0);
      tick();
`ifdef PC_UNIT_PERF_EN
      chk("cnt_three", taken_cnt, 32'd3);
`else
      chk("cnt_three", taken_cnt, 32'd0);
`endif

      // reset back to RESET_PC
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst2_pc", pc, 32'h8000_0000);
      chk("rst2_cnt", taken_cnt, 32'd0);

      // JAL and branch together, JAL wins
      drive(1, 1, 1, 0, 0, 32'd8, 32'd0);
      #1;
      chk("jal_link", link, 32'h8000_0004);
      tick();
      chk("jal_pc", pc, 32'h8000_0008);
      chk("jal_redirect", {31'd0, redirect}, 32'd1);

      // hold a taken branch through FLUSH: ignored, then accepted
      drive(1, 1, 0, 0, 1, 32'h0000_0010, 32'd0);
      tick();
      chk("flush_pc", pc, 32'h8000_0008);
      chk("flush_redirect", {31'd0, redirect}, 32'd0);
      chk("flush_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("held_pc", pc, 32'h8000_0018);
      chk("held_redirect", {31'd0, redirect}, 32'd1);
      chk("held_ready", {31'd0, in_ready}, 32'd0);
`ifdef PC_UNIT_PERF_EN
      chk("cnt_two", taken_cnt, 32'd2);
`else
      chk("cnt_two", taken_cnt, 32'd0);
`endif

      // reset during FLUSH, with a taken branch still presented
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rstf_pc", pc, 32'h8000_0000);
      chk("rstf_redirect", {31'd0, redirect}, 32'd0);
      chk("rstf_ready", {31'd0, in_ready}, 32'd1);
      chk("rstf_cnt", taken_cnt, 32'd0);

      // reset wins over a simultaneous accept from RUN
      drive(1, 0, 1, 0, 0, 32'h0000_0040, 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_acc_pc", pc, 32'h8000_0000);
      chk("rst_acc_redirect", {31'd0, redirect}, 32'd0);

      // 5 taken (imm 0, stay in place) + 3 not-taken
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 0, 0, 1, 32'd0, 32'd0);
         tick();
         chk("perf_t_redirect", {31'd0, redirect}, 32'd1);
         drive(0, 0, 0, 0, 0, 32'd0, 32'd0);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 0, 0, 32'd0, 32'd0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 32'd0, 32'd0);
      chk("perf_pc", pc, 32'h8000_000C);
`ifdef PC_UNIT_PERF_EN
      exp_cnt = 32'd5;
`else
      exp_cnt = 32'd0;
`endif
      chk("perf_cnt", taken_cnt, exp_cnt);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("perf_cnt_rst", taken_cnt, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
